// File: rtl/issue_unit_dispatcher_pkg.sv
// Types shared by the issue-queue dispatchers: execute-unit class and the issue->execute payload.
// credit_width() sizes a credit counter that holds 0..depth inclusive.
package issue_unit_dispatcher_pkg;

    typedef enum logic [2:0] {
        OP_ALU = 3'd0,
        OP_BRU = 3'd1,
        OP_CSR = 3'd2,
        OP_DIV = 3'd3,
        OP_LSU = 3'd4,
        OP_MUL = 3'd5
    } op_unit_t;

    typedef struct packed {
        op_unit_t    unit;
        logic [4:0]  opcode;
        logic [7:0]  rob_id;
        logic [47:0] imm;
        logic [63:0] operand;
    } issue_execute_pack_t;

    function automatic int credit_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/issue_dispatch_credit.sv
// One execute-FIFO credit counter: starts full, -1 per grant, +1 per pop, refilled by flush.
// Next-cycle update; grant and pop together cancel. A pop while already full saturates.
module issue_dispatch_credit
    import issue_unit_dispatcher_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CW         = credit_width(FIFO_DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          grant,
    input  logic          pop,
    output logic [CW-1:0] count,
    output logic          nonzero
);

    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] ONE  = CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= FULL;
        end else if (flush) begin
            count <= FULL;
        end else if (grant && !pop) begin
            count <= count - ONE;
        end else if (pop && !grant && count != FULL) begin
            count <= count + ONE;
        end
    end

    assign nonzero = (count != '0);

    // The execute side can never hold more entries than the FIFO has.
    pop_when_full: assert property (@(posedge clk) disable iff (rst || flush)
        !(pop && count == FULL));

endmodule

// File: rtl/issue_unit_dispatcher.sv
// Round-robin, in-order credit dispatcher; grants are comb, pushes registered (1 cycle), zero-credit units skipped.
// Optional ISSUE_DISPATCH_STAT_EN adds saturating stat_dispatched / stat_stall_cycles counters.
module issue_unit_dispatcher
    import issue_unit_dispatcher_pkg::*;
#(
    parameter int ISSUE_WIDTH = 2,
    parameter int UNIT_NUM    = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int DATA_WIDTH  = $bits(issue_execute_pack_t)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic [ISSUE_WIDTH-1:0]            req_valid,
    input  logic [ISSUE_WIDTH*DATA_WIDTH-1:0] req_data,
    output logic [ISSUE_WIDTH-1:0]            req_ready,
    input  logic [UNIT_NUM-1:0]               unit_pop,
    output logic [UNIT_NUM-1:0]               fifo_push,
    output logic [UNIT_NUM*DATA_WIDTH-1:0]    fifo_data,
    output logic                              full_add,
`ifdef ISSUE_DISPATCH_STAT_EN
    output logic [31:0]                       stat_dispatched,
    output logic [31:0]                       stat_stall_cycles,
`endif
    output logic                              stall
);

    localparam int CW = credit_width(FIFO_DEPTH);
    localparam int RW = (UNIT_NUM > 1) ? $clog2(UNIT_NUM) : 1;
    localparam int SW = (ISSUE_WIDTH > 1) ? $clog2(ISSUE_WIDTH) : 1;

    logic [RW-1:0]       rr_ptr;
    logic [RW-1:0]       rr_next;
    logic [UNIT_NUM-1:0] unit_grant;
    logic [UNIT_NUM-1:0] unit_nonzero;
    logic [SW-1:0]       unit_slot [UNIT_NUM];
    logic [CW-1:0]       credit    [UNIT_NUM];
    logic                denied;
    logic                any_grant;
    logic                full_cond;

    genvar g;
    generate
        for (g = 0; g < UNIT_NUM; g++) begin : g_credit
            issue_dispatch_credit #(
                .FIFO_DEPTH (FIFO_DEPTH),
                .CW         (CW)
            ) u_credit (
                .clk     (clk),
                .rst     (rst),
                .flush   (flush),
                .grant   (unit_grant[g]),
                .pop     (unit_pop[g]),
                .count   (credit[g]),
                .nonzero (unit_nonzero[g])
            );

            grant_needs_credit: assert property (@(posedge clk) disable iff (rst)
                unit_grant[g] |-> credit[g] != '0);
        end
    endgenerate

    // Each valid slot takes the next untaken unit with credit, scanning from rr_ptr;
    // the first valid slot that finds none blocks every younger slot.
    always_comb begin
        logic blocked;
        logic found;
        int   u;
        int   last_u;
        unit_grant = '0;
        req_ready  = '0;
        denied     = 1'b0;
        any_grant  = 1'b0;
        blocked    = 1'b0;
        found      = 1'b0;
        u          = 0;
        last_u     = 0;
        for (int s = 0; s < UNIT_NUM; s++) begin
            unit_slot[s] = '0;
        end
        for (int i = 0; i < ISSUE_WIDTH; i++) begin
            found = 1'b0;
            if (req_valid[i] && !flush && !blocked) begin
                for (int k = 0; k < UNIT_NUM; k++) begin
                    u = (int'(rr_ptr) + k) % UNIT_NUM;
                    if (!found && unit_nonzero[u] && !unit_grant[u]) begin
                        found         = 1'b1;
                        unit_grant[u] = 1'b1;
                        unit_slot[u]  = SW'(i);
                        last_u        = u;
                    end
                end
            end
            if (req_valid[i] && !flush) begin
                if (found) begin
                    req_ready[i] = 1'b1;
                    any_grant    = 1'b1;
                end else begin
                    blocked = 1'b1;
                    denied  = 1'b1;
                end
            end
        end
        rr_next   = any_grant ? RW'((last_u + 1) % UNIT_NUM) : rr_ptr;
        full_cond = denied && !(|unit_nonzero);
    end

    assign stall = denied;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_push <= '0;
            fifo_data <= '0;
            full_add  <= 1'b0;
            rr_ptr    <= '0;
        end else if (flush) begin
            fifo_push <= '0;
            fifo_data <= '0;
            full_add  <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            fifo_push <= unit_grant;
            full_add  <= full_cond;
            rr_ptr    <= rr_next;
            for (int u2 = 0; u2 < UNIT_NUM; u2++) begin
                if (unit_grant[u2]) begin
                    fifo_data[u2*DATA_WIDTH +: DATA_WIDTH] <=
                        req_data[int'(unit_slot[u2])*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

`ifdef ISSUE_DISPATCH_STAT_EN
    logic [31:0] grant_cnt;
    assign grant_cnt = 32'($countones(req_ready));

    // Perf counters survive flush; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_dispatched   <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (stat_dispatched > (32'hFFFF_FFFF - grant_cnt)) begin
                stat_dispatched <= 32'hFFFF_FFFF;
            end else begin
                stat_dispatched <= stat_dispatched + grant_cnt;
            end
            if (stall && stat_stall_cycles != 32'hFFFF_FFFF) begin
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_issue_unit_dispatcher.sv
// Directed bench for issue_unit_dispatcher (2 slots, 2 units, depth 4) with a queue-based reference model.
module tb_issue_unit_dispatcher;

    localparam int DW = 128;

    logic           clk = 1'b0;
    logic           rst;
    logic           flush;
    logic [1:0]     req_valid;
    logic [2*DW-1:0] req_data;
    logic [1:0]     req_ready;
    logic [1:0]     unit_pop;
    logic [1:0]     fifo_push;
    logic [2*DW-1:0] fifo_data;
    logic           full_add;
    logic           stall;
`ifdef ISSUE_DISPATCH_STAT_EN
    logic [31:0]    stat_dispatched;
    logic [31:0]    stat_stall_cycles;
`endif

    issue_unit_dispatcher #(
        .ISSUE_WIDTH (2),
        .UNIT_NUM    (2),
        .FIFO_DEPTH  (4),
        .DATA_WIDTH  (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .unit_pop  (unit_pop),
        .fifo_push (fifo_push),
        .fifo_data (fifo_data),
        .full_add  (full_add),
`ifdef ISSUE_DISPATCH_STAT_EN
        .stat_dispatched   (stat_dispatched),
        .stat_stall_cycles (stat_stall_cycles),
`endif
        .stall     (stall)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [2*DW-1:0] act, input logic [2*DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model state: what the registered outputs hold after the next edge.
    int              m_credit [2];
    int              m_rr;
    logic [1:0]      m_push;
    logic [2*DW-1:0] m_data;
    logic            m_full;
    int              m_disp;
    int              m_stallc;

    always @(negedge clk) begin
        int              elig [$];
        logic [1:0]      g;
        logic [1:0]      exp_ready;
        logic [2*DW-1:0] gd;
        logic            blocked;
        logic            denied;
        int              last;
        int              u;
        if (rst) begin
            m_credit[0] = 4;
            m_credit[1] = 4;
            m_rr        = 0;
            m_push      = '0;
            m_data      = '0;
            m_full      = 1'b0;
            m_disp      = 0;
            m_stallc    = 0;
        end else begin
            elig.delete();
            for (int k = 0; k < 2; k++) begin
                u = (m_rr + k) % 2;
                if (m_credit[u] > 0) elig.push_back(u);
            end
            g = '0; exp_ready = '0; gd = m_data; blocked = 1'b0; denied = 1'b0; last = 0;
            if (!flush) begin
                for (int i = 0; i < 2; i++) begin
                    if (req_valid[i]) begin
                        if (!blocked && elig.size() > 0) begin
                            u = elig.pop_front();
                            exp_ready[i] = 1'b1;
                            g[u] = 1'b1;
                            gd[u*DW +: DW] = req_data[i*DW +: DW];
                            last = u;
                        end else begin
                            blocked = 1'b1;
                            denied  = 1'b1;
                        end
                    end
                end
            end
            check("req_ready", req_ready, exp_ready);
            check("stall", stall, denied);
            check("fifo_push", fifo_push, m_push);
            check("fifo_data", fifo_data, m_data);
            check("full_add", full_add, m_full);

            m_disp   += $countones(exp_ready);
            m_stallc += int'(denied);
            if (flush) begin
                m_credit[0] = 4;
                m_credit[1] = 4;
                m_rr        = 0;
                m_push      = '0;
                m_data      = '0;
                m_full      = 1'b0;
            end else begin
                m_full = denied && m_credit[0] == 0 && m_credit[1] == 0;
                m_push = g;
                m_data = gd;
                if (g != 2'b00) m_rr = (last + 1) % 2;
                for (int k = 0; k < 2; k++) begin
                    m_credit[k] = m_credit[k] - int'(g[k]) + int'(unit_pop[k]);
                    if (m_credit[k] > 4) m_credit[k] = 4;
                end
            end
        end
    end

    logic [1:0] r_ready;
    logic       r_stall;

    task automatic cyc(input logic [1:0] v, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [1:0] pop, input logic fl);
        req_valid = v;
        req_data  = {d1, d0};
        unit_pop  = pop;
        flush     = fl;
        #2;
        r_ready = req_ready;
        r_stall = stall;
        @(posedge clk);
        #1;
    endtask

    localparam logic [DW-1:0] Z  = '0;
    localparam logic [DW-1:0] DA = {4{32'hAAAA_0001}};
    localparam logic [DW-1:0] DB = {4{32'hBBBB_0002}};
    localparam logic [DW-1:0] DG = {4{32'h6666_0007}};
    localparam logic [DW-1:0] DH = {4{32'h7777_0008}};
    localparam logic [DW-1:0] DK = {4{32'hCCCC_000B}};
    localparam logic [DW-1:0] DM = {4{32'hDDDD_000D}};
    localparam logic [DW-1:0] DR = {4{32'h1212_0012}};
    localparam logic [DW-1:0] DS = {4{32'h1313_0013}};
    localparam logic [DW-1:0] DU = {4{32'h1515_0015}};

    initial begin
        rst = 1'b1; flush = 1'b0; req_valid = '0; req_data = '0; unit_pop = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // reset state
        check("rst_push", fifo_push, 2'b00);
        check("rst_full", full_add, 1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_credit0", m_credit[0], 4);
        check("rst_credit1", m_credit[1], 4);
        cyc(2'b00, Z, Z, 2'b00, 1'b0);

        // two slots to two units
        cyc(2'b11, DA, DB, 2'b00, 1'b0);
        check("t2_ready", r_ready, 2'b11);
        check("t2_push", fifo_push, 2'b11);
        check("t2_data", fifo_data, {DB, DA});
        check("t2_rr", m_rr, 0);
        check("t2_credit0", m_credit[0], 3);

        // drain all credits, then pure backpressure
        cyc(2'b11, {4{32'h3}}, {4{32'h4}}, 2'b00, 1'b0);
        cyc(2'b11, {4{32'h5}}, {4{32'h6}}, 2'b00, 1'b0);
        cyc(2'b11, DG, DH, 2'b00, 1'b0);
        check("t3_credit1", m_credit[1], 0);
        check("t3_data", fifo_data, {DH, DG});
        cyc(2'b11, {4{32'h9}}, {4{32'hA}}, 2'b00, 1'b0);
        check("t3_ready", r_ready, 2'b00);
        check("t3_stall", r_stall, 1'b1);
        check("t3_full", full_add, 1'b1);
        check("t3_held", fifo_data, {DH, DG});

        // credits 0,1: slot0 to unit1, slot1 denied without full_add
        cyc(2'b00, Z, Z, 2'b10, 1'b0);
        check("t4_full_clr", full_add, 1'b0);
        cyc(2'b11, DK, {4{32'hE}}, 2'b00, 1'b0);
        check("t4_ready", r_ready, 2'b01);
        check("t4_stall", r_stall, 1'b1);
        check("t4_full", full_add, 1'b0);
        check("t4_push", fifo_push, 2'b10);
        check("t4_data", fifo_data, {DK, DG});
        check("t4_rr", m_rr, 0);

        // grant and pop together on unit0
        cyc(2'b00, Z, Z, 2'b01, 1'b0);
        cyc(2'b01, DM, Z, 2'b01, 1'b0);
        check("t5_ready", r_ready, 2'b01);
        check("t5_push", fifo_push, 2'b01);
        check("t5_credit0", m_credit[0], 1);
        cyc(2'b01, {4{32'hF}}, Z, 2'b00, 1'b0);
        check("t5_regrant", r_ready, 2'b01);

        // flush with valid requests and pops
        cyc(2'b00, Z, Z, 2'b11, 1'b0);
        cyc(2'b11, {4{32'h10}}, {4{32'h11}}, 2'b11, 1'b1);
        check("t6_ready", r_ready, 2'b00);
        check("t6_stall", r_stall, 1'b0);
        check("t6_push", fifo_push, 2'b00);
        check("t6_data", fifo_data, {Z, Z});
        check("t6_credit0", m_credit[0], 4);
        check("t6_rr", m_rr, 0);
        cyc(2'b11, DR, DS, 2'b00, 1'b0);
        check("t6_regrant", fifo_data, {DS, DR});

        // single-slot round robin and an invalid oldest slot
        cyc(2'b01, {4{32'h14}}, Z, 2'b00, 1'b0);
        check("rr_push0", fifo_push, 2'b01);
        cyc(2'b01, DU, Z, 2'b00, 1'b0);
        check("rr_push1", fifo_push, 2'b10);
        check("rr_data1", fifo_data[DW +: DW], DU);
        cyc(2'b10, Z, {4{32'h16}}, 2'b00, 1'b0);
        check("gap_ready", r_ready, 2'b10);
        check("gap_push", fifo_push, 2'b01);
        cyc(2'b00, Z, Z, 2'b00, 1'b0);

`ifdef ISSUE_DISPATCH_STAT_EN
        check("stat_disp", stat_dispatched, 32'd16);
        check("stat_stall", stat_stall_cycles, 32'd2);
        check("stat_disp_model", stat_dispatched, 32'(m_disp));
        check("stat_stall_model", stat_stall_cycles, 32'(m_stallc));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
